// File: rtl/scmp_pkg.sv
// Shared compare-mode encodings, flag bundle and helpers for the scmp_stream comparator.
package scmp_pkg;

  typedef enum logic [2:0] {
    CMP_GT = 3'd0,
    CMP_GE = 3'd1,
    CMP_LT = 3'd2,
    CMP_LE = 3'd3,
    CMP_EQ = 3'd4,
    CMP_NE = 3'd5
  } cmp_mode_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  // One guard bit is enough to hold any signed or unsigned difference exactly.
  function automatic int ext_w(input int width);
    return width + 1;
  endfunction

  function automatic logic cmp_select(input logic [2:0] mode, input cmp_flags_t f);
    logic r;
    case (mode)
      CMP_GT:  r = f.gt;
      CMP_GE:  r = f.gt | f.eq;
      CMP_LT:  r = f.lt;
      CMP_LE:  r = f.lt | f.eq;
      CMP_EQ:  r = f.eq;
      CMP_NE:  r = ~f.eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scmp_core.sv
// Extend-and-subtract comparator: a - b in WIDTH+1 bits, plus the LT/EQ/GT flags of that difference.
module scmp_core
  import scmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]        a_i,
  input  logic [WIDTH-1:0]        b_i,
  input  logic                    signed_i,
  output logic [ext_w(WIDTH)-1:0] diff_o,
  output cmp_flags_t              flags_o
);

  localparam int EW = ext_w(WIDTH);

  logic [EW-1:0] a_x;
  logic [EW-1:0] b_x;

  assign a_x = {signed_i & a_i[WIDTH-1], a_i};
  assign b_x = {signed_i & b_i[WIDTH-1], b_i};

  assign diff_o     = a_x - b_x;
  assign flags_o.lt = diff_o[EW-1];
  assign flags_o.eq = (diff_o == '0);
  assign flags_o.gt = ~diff_o[EW-1] & (diff_o != '0);

endmodule

// File: rtl/scmp_stream.sv
// Two-stage valid/ready stream comparator with a per-packet running max/min of I0 and its beat index.
module scmp_stream
  import scmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       MODE,
  input  logic             SIGNED,
  input  logic             MAXSEL,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             O,
  output logic [WIDTH-1:0] EXT,
  output logic [IDX_W-1:0] EXT_IDX,
  output logic             OUT_LAST
);

  localparam int EW = ext_w(WIDTH);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  logic             s1_v_q, s1_v_d;
  logic [EW-1:0]    d_q, d_d;
  logic [WIDTH-1:0] i0_q, i0_d;
  logic [2:0]       mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic             maxsel_q, maxsel_d;
  logic             last_q, last_d;

  logic             s2_v_q, s2_v_d;
  logic             o_q, o_d;
  logic [WIDTH-1:0] ext_q, ext_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             olast_q, olast_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  logic             s1_adv, s2_adv, s2_load;
  logic [EW-1:0]    s1_diff;
  cmp_flags_t       s1_flags_unused;
  logic [EW-1:0]    s2_diff_unused;
  cmp_flags_t       best_flags;
  cmp_flags_t       res_flags;

  scmp_core #(.WIDTH(WIDTH)) u_cmp_in (
    .a_i      (I0),
    .b_i      (I1),
    .signed_i (SIGNED),
    .diff_o   (s1_diff),
    .flags_o  (s1_flags_unused)
  );

  // ext_q doubles as the stored packet best, so the beat compares against it directly.
  scmp_core #(.WIDTH(WIDTH)) u_cmp_best (
    .a_i      (i0_q),
    .b_i      (ext_q),
    .signed_i (sgn_q),
    .diff_o   (s2_diff_unused),
    .flags_o  (best_flags)
  );

  assign s2_adv   = ~s2_v_q | OUT_READY;
  assign s1_adv   = ~s1_v_q | s2_adv;
  assign s2_load  = s1_v_q & s2_adv;
  assign IN_READY = RESETN & s1_adv;

  assign res_flags.lt = d_q[EW-1];
  assign res_flags.eq = (d_q == '0);
  assign res_flags.gt = ~d_q[EW-1] & (d_q != '0);

  always_comb begin
    s1_v_d   = s1_v_q;
    d_d      = d_q;
    i0_d     = i0_q;
    mode_d   = mode_q;
    sgn_d    = sgn_q;
    maxsel_d = maxsel_q;
    last_d   = last_q;
    s2_v_d   = s2_v_q;
    o_d      = o_q;
    ext_d    = ext_q;
    idx_d    = idx_q;
    olast_d  = olast_q;
    cnt_d    = cnt_q;
    first_d  = first_q;

    if (s1_adv) begin
      s1_v_d = IN_VALID;
      if (IN_VALID) begin
        d_d      = s1_diff;
        i0_d     = I0;
        mode_d   = MODE;
        sgn_d    = SIGNED;
        maxsel_d = MAXSEL;
        last_d   = IN_LAST;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
    end

    if (s2_load) begin
      o_d     = cmp_select(mode_q, res_flags);
      olast_d = last_q;
      if (first_q) begin
        ext_d   = i0_q;
        idx_d   = '0;
        cnt_d   = IDX_W'(1);
        first_d = 1'b0;
      end else begin
        // Strict compare: ties keep the earliest index.
        if (maxsel_q ? best_flags.gt : best_flags.lt) begin
          ext_d = i0_q;
          idx_d = cnt_q;
        end
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      if (last_q) begin
        first_d = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      s1_v_q   <= 1'b0;
      d_q      <= '0;
      i0_q     <= '0;
      mode_q   <= '0;
      sgn_q    <= 1'b0;
      maxsel_q <= 1'b0;
      last_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      o_q      <= 1'b0;
      ext_q    <= '0;
      idx_q    <= '0;
      olast_q  <= 1'b0;
      cnt_q    <= '0;
      first_q  <= 1'b1;
    end else begin
      s1_v_q   <= s1_v_d;
      d_q      <= d_d;
      i0_q     <= i0_d;
      mode_q   <= mode_d;
      sgn_q    <= sgn_d;
      maxsel_q <= maxsel_d;
      last_q   <= last_d;
      s2_v_q   <= s2_v_d;
      o_q      <= o_d;
      ext_q    <= ext_d;
      idx_q    <= idx_d;
      olast_q  <= olast_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  assign OUT_VALID = s2_v_q;
  assign O         = o_q;
  assign EXT       = ext_q;
  assign EXT_IDX   = idx_q;
  assign OUT_LAST  = olast_q;

endmodule

// File: tb/tb_scmp_stream.sv
// Bench for scmp_stream: two instances (IDX_W=8 and IDX_W=2) share stimulus; a packet-level model scores every output.
module tb_scmp_stream;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] I0, I1;
  logic [2:0] MODE;
  logic       SIGNED, MAXSEL, IN_LAST;
  logic       OUT_VALID, OUT_READY, O, OUT_LAST;
  logic [7:0] EXT, EXT_IDX;

  logic       in_ready_b, out_valid_b, o_b, out_last_b;
  logic [7:0] ext_b;
  logic [1:0] ext_idx_b;

  always #5 CLK = ~CLK;

  scmp_stream #(.WIDTH(8), .IDX_W(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .I0(I0), .I1(I1), .MODE(MODE), .SIGNED(SIGNED), .MAXSEL(MAXSEL), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .O(O), .EXT(EXT), .EXT_IDX(EXT_IDX),
    .OUT_LAST(OUT_LAST)
  );

  scmp_stream #(.WIDTH(8), .IDX_W(2)) dut_b (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .IN_READY(in_ready_b),
    .I0(I0), .I1(I1), .MODE(MODE), .SIGNED(SIGNED), .MAXSEL(MAXSEL), .IN_LAST(IN_LAST),
    .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY), .O(o_b), .EXT(ext_b), .EXT_IDX(ext_idx_b),
    .OUT_LAST(out_last_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       o;
    logic [7:0] ext;
    logic [7:0] idx_a;
    logic [1:0] idx_b;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  logic  saw_full = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int sx(input logic [7:0] v, input logic s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  // Packet model: plain integer compare plus a fold over the packet's beats.
  bit         pk_first = 1'b1;
  int         pk_pos   = 0;
  int         pk_bpos  = 0;
  logic [7:0] pk_best  = 8'h00;

  function automatic beat_t model_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                                       input logic s, input logic mx, input logic l);
    beat_t e;
    int ia, ib, ic;
    ia = sx(a, s);
    ib = sx(b, s);
    case (m)
      3'd0: e.o = (ia > ib);
      3'd1: e.o = (ia >= ib);
      3'd2: e.o = (ia < ib);
      3'd3: e.o = (ia <= ib);
      3'd4: e.o = (ia == ib);
      3'd5: e.o = (ia != ib);
      default: e.o = 1'b0;
    endcase
    if (pk_first) begin
      pk_best  = a;
      pk_pos   = 0;
      pk_bpos  = 0;
      pk_first = 1'b0;
    end else begin
      pk_pos++;
      ic = sx(pk_best, s);
      if (mx ? (ia > ic) : (ia < ic)) begin
        pk_best = a;
        pk_bpos = pk_pos;
      end
    end
    e.ext   = pk_best;
    e.idx_a = 8'((pk_bpos > 255) ? 255 : pk_bpos);
    e.idx_b = 2'((pk_bpos > 3) ? 3 : pk_bpos);
    e.last  = l;
    if (l) pk_first = 1'b1;
    return e;
  endfunction

  // Per-cycle checker sampling on the falling edge.
  initial begin
    beat_t e, held, act;
    logic stall_prev;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (!RESETN) begin
        exp_q.delete();
        pk_first   = 1'b1;
        stall_prev = 1'b0;
      end else begin
        chk("in_ready_occupancy", IN_READY, (exp_q.size() == 2 && !OUT_READY) ? 0 : 1);
        chk("pair_out_valid", out_valid_b, OUT_VALID);
        chk("pair_in_ready", in_ready_b, IN_READY);
        if (!IN_READY) saw_full = 1'b1;
        act = '{o: O, ext: EXT, idx_a: EXT_IDX, idx_b: ext_idx_b, last: OUT_LAST};
        if (stall_prev) begin
          chk("hold_valid", OUT_VALID, 1);
          chk("hold_data", act, held);
        end
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output_queue_size", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("sb_o", O, e.o);
            chk("sb_ext", EXT, e.ext);
            chk("sb_idx", EXT_IDX, e.idx_a);
            chk("sb_last", OUT_LAST, e.last);
            chk("sb_b_o", o_b, e.o);
            chk("sb_b_ext", ext_b, e.ext);
            chk("sb_b_idx", ext_idx_b, e.idx_b);
            chk("sb_b_last", out_last_b, e.last);
            log_q.push_back(act);
          end
        end
        stall_prev = OUT_VALID && !OUT_READY;
        held = act;
        if (IN_VALID && IN_READY)
          exp_q.push_back(model_beat(I0, I1, MODE, SIGNED, MAXSEL, IN_LAST));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                      input logic s, input logic mx, input logic l);
    int n;
    @(posedge CLK); #1;
    IN_VALID = 1'b1; I0 = a; I1 = b; MODE = m; SIGNED = s; MAXSEL = mx; IN_LAST = l;
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("send_accept", IN_READY, 1);
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int c;
    c = 0;
    while (log_q.size() < n && c < 200) begin
      @(negedge CLK);
      c++;
    end
    chk("wait_log", log_q.size(), n);
  endtask

  task automatic chk_rec(input string nm, input int k, input logic o, input logic [7:0] ext,
                         input logic [7:0] ia, input logic [1:0] ib, input logic l);
    beat_t r;
    r = '{o: o, ext: ext, idx_a: ia, idx_b: ib, last: l};
    if (k < log_q.size()) chk(nm, log_q[k], r);
    else chk({nm, "_missing"}, log_q.size(), k + 1);
  endtask

  initial begin
    int         base;
    logic [6:0] mode_exp;
    logic [7:0] pkt [5];
    logic [7:0] bp_i0 [6];
    logic [7:0] bp_ext [6];
    logic [7:0] bp_idx [6];
    logic [5:0] bp_o;
    logic [2:0] rdy_pat;

    RESETN = 1'b0; IN_VALID = 1'b0; I0 = '0; I1 = '0; MODE = '0;
    SIGNED = 1'b0; MAXSEL = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b1;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_o", O, 0);
    chk("rst_ext", EXT, 0);
    chk("rst_ext_idx", EXT_IDX, 0);
    chk("rst_out_last", OUT_LAST, 0);
    @(posedge CLK); #1;
    RESETN = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", IN_READY, 1);

    // Signed vs unsigned GT with latency check
    base = log_q.size();
    send(8'h7F, 8'h80, 3'd0, 1'b1, 1'b1, 1'b1);
    idle();
    @(negedge CLK);
    chk("latency_cycle1_valid", OUT_VALID, 0);
    @(negedge CLK);
    chk("latency_cycle2_valid", OUT_VALID, 1);
    send(8'h7F, 8'h80, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_log(base + 2);
    chk_rec("gt_signed", base, 1'b1, 8'h7F, 8'd0, 2'd0, 1'b1);
    chk_rec("gt_unsigned", base + 1, 1'b0, 8'h7F, 8'd0, 2'd0, 1'b1);

    // All modes on equal operands, back to back
    base = log_q.size();
    mode_exp = 7'b0011010;
    for (int m = 0; m < 7; m++) send(8'hC3, 8'hC3, 3'(m), 1'b1, 1'b1, 1'b1);
    idle();
    wait_log(base + 7);
    for (int m = 0; m < 7; m++)
      chk_rec($sformatf("mode_%0d", m), base + m, mode_exp[m], 8'hC3, 8'd0, 2'd0, 1'b1);

    // Running max then min over a signed packet
    pkt[0] = 8'hFD; pkt[1] = 8'h05; pkt[2] = 8'h05; pkt[3] = 8'h80; pkt[4] = 8'h02;
    base = log_q.size();
    for (int k = 0; k < 5; k++) send(pkt[k], 8'h00, 3'd0, 1'b1, 1'b1, 1'(k == 4));
    for (int k = 0; k < 5; k++) send(pkt[k], 8'h00, 3'd0, 1'b1, 1'b0, 1'(k == 4));
    idle();
    wait_log(base + 10);
    chk_rec("pkt_max_beat2", base + 2, 1'b1, 8'h05, 8'd1, 2'd1, 1'b0);
    chk_rec("pkt_max_final", base + 4, 1'b1, 8'h05, 8'd1, 2'd1, 1'b1);
    chk_rec("pkt_min_final", base + 9, 1'b1, 8'h80, 8'd3, 2'd3, 1'b1);

    // Backpressure: OUT_READY follows 1,0,0 repeating
    bp_i0  = '{8'h20, 8'h30, 8'h25, 8'h40, 8'h10, 8'h50};
    bp_ext = '{8'h20, 8'h30, 8'h30, 8'h40, 8'h40, 8'h50};
    bp_idx = '{8'd0, 8'd1, 8'd1, 8'd3, 8'd3, 8'd5};
    bp_o   = 6'b101010;
    rdy_pat = 3'b001;
    base = log_q.size();
    saw_full = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(bp_i0[k], 8'h28, 3'd0, 1'b0, 1'b1, 1'(k == 5));
        idle();
      end
      begin
        for (int c = 0; c < 24; c++) begin
          @(posedge CLK); #1;
          OUT_READY = rdy_pat[c % 3];
        end
        OUT_READY = 1'b1;
      end
    join
    wait_log(base + 6);
    chk("bp_full_stall_seen", saw_full, 1);
    for (int k = 0; k < 6; k++)
      chk_rec($sformatf("bp_beat%0d", k), base + k, bp_o[k], bp_ext[k], bp_idx[k],
              2'((bp_idx[k] > 3) ? 3 : bp_idx[k]), 1'(k == 5));

    // Reset with two beats of an open packet in flight
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    send(8'h50, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    send(8'h60, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();
    @(negedge CLK);
    chk("midrst_pipe_full_ready", IN_READY, 0);
    @(posedge CLK); #1;
    RESETN = 1'b0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    OUT_READY = 1'b1;
    base = log_q.size();
    @(negedge CLK);
    chk("midrst_out_valid", OUT_VALID, 0);
    repeat (3) @(negedge CLK);
    chk("midrst_no_output", log_q.size(), base);
    send(8'h10, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    idle();
    wait_log(base + 1);
    chk_rec("midrst_first_beat", base, 1'b1, 8'h10, 8'd0, 2'd0, 1'b1);

    // Index saturation on the IDX_W=2 instance
    base = log_q.size();
    for (int k = 0; k < 6; k++) send(8'(k + 1), 8'h03, 3'd0, 1'b0, 1'b1, 1'(k == 5));
    idle();
    wait_log(base + 6);
    for (int k = 0; k < 6; k++)
      chk_rec($sformatf("sat_beat%0d", k), base + k, 1'(k >= 3), 8'(k + 1), 8'(k),
              2'((k > 3) ? 3 : k), 1'(k == 5));

    repeat (4) @(negedge CLK);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scmp_stream.md
Name: scmp_stream

Overview:
- Parametrised, pipelined comparator for streams of WIDTH-bit operands.
- Supports signed/unsigned operation and six compare modes, selected per beat.
- Tracks a per-packet running extremum (max or min) of I0 together with its beat index.
- Sits between a valid/ready producer and consumer in the datapath. It replaces fixed-width, purely combinational greater-than blocks with a backpressure-aware two-stage unit.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- IDX_W, 8, width of the beat-index counter and the EXT_IDX output.

Ports:
- CLK  in  1  clock, rising edge
- RESETN  in  1  synchronous active-low reset
- IN_VALID  in  1  input beat valid
- IN_READY  out  1  unit can accept a beat this cycle
- I0  in  WIDTH  operand A
- I1  in  WIDTH  operand B
- MODE  in  3  0=GT, 1=GE, 2=LT, 3=LE, 4=EQ, 5=NE, 6/7=reserved (result 0)
- SIGNED  in  1  1 = two's-complement compare, 0 = unsigned
- MAXSEL  in  1  1 = extremum tracks max of I0, 0 = min
- IN_LAST  in  1  last beat of packet
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  consumer accepts output beat
- O  out  1  result of (I0 MODE I1)
- EXT  out  WIDTH  running extremum of I0 in the packet, including this beat
- EXT_IDX  out  IDX_W  beat index of EXT within the packet
- OUT_LAST  out  1  echoes IN_LAST

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-low: RESETN is sampled on the rising edge of CLK. While low:
  - both stage-valid flags are cleared; OUT_VALID=0, O=0, EXT=0, EXT_IDX=0, OUT_LAST=0;
  - beat counter=0 and first-beat flag=1;
  - IN_READY=0 while RESETN=0 and 1 on the first cycle after release.
- Reset mid-packet discards all in-flight beats and partial extremum state. No output beat is produced for them.
- Handshake:
  - input transfer when IN_VALID && IN_READY; output transfer when OUT_VALID && OUT_READY;
  - OUT_VALID and all output data stay stable while OUT_VALID && !OUT_READY;
  - s2_adv = !s2_v || OUT_READY; IN_READY = !s1_v || s2_adv (combinational from OUT_READY is permitted);
  - full throughput of 1 beat/cycle while OUT_READY=1.
- Latency: 2 cycles from input transfer to OUT_VALID when there is no backpressure.
- Stage 1 registers:
  - d = ext(I0) - ext(I1) in WIDTH+1 bits. ext is sign-extension when SIGNED=1, zero-extension otherwise.
  - also I0, MODE, SIGNED, MAXSEL, IN_LAST.
- Stage 2, result:
  - LT = d[WIDTH]; EQ = (d==0); GT = !LT && !EQ.
  - O is selected per MODE. Reserved modes give O=0.
- Stage 2, extremum update (on the stage-2 load):
  - First beat (first-beat flag=1): best=I0, idx=0, counter=1, flag cleared.
  - Otherwise compute e = ext(I0) - ext(best) with the beat's SIGNED. Replace best/idx=counter if e>0 (MAXSEL=1) or e<0 (MAXSEL=0).
  - Ties keep the earliest index.
  - counter increments and saturates at 2^IDX_W-1. Beats past saturation all report that index.
  - When the beat has IN_LAST=1, the flag is set and counter=0 after the load.
- Mixing SIGNED/MAXSEL within a packet is legal. Each beat uses its own settings against the stored best bits.
- Boundaries:
  - full pipe + OUT_READY=0 → IN_READY=0, no data lost;
  - simultaneous output drain and input accept in the same cycle is required;
  - a single-beat packet (IN_LAST on first beat) gives EXT=I0, EXT_IDX=0.

Decomposition:
- Package scmp_pkg: MODE encodings (CMP_GT..CMP_NE) and a function/constant for the extension width (WIDTH+1).
- Sub-module scmp_core: combinational WIDTH+1-bit extend-and-subtract returning {LT, EQ, GT}.
  - one instance for I0-vs-I1 (stage 1, diff registered);
  - one instance for I0-vs-best (stage 2).

Test Plan:
- WIDTH=8, SIGNED=1, GT: I0=8'h7F, I1=8'h80 → O=1. With SIGNED=0 → O=0. Both arrive 2 cycles after the accept.
- All six modes on I0=I1=8'hC3 → GT=0, GE=1, LT=0, LE=1, EQ=1, NE=0. MODE=6 → O=0.
- Packet of I0 = {-3, 5, 5, -128, 2}, SIGNED=1, MAXSEL=1, LAST on the 5th beat → final EXT=5, EXT_IDX=1. The same packet with MAXSEL=0 → EXT=8'h80, EXT_IDX=3.
- Backpressure: stream 6 beats with OUT_READY toggling 1,0,0,1,… → outputs hold stable while stalled, IN_READY=0 when both stages are full, all 6 results arrive in order, none lost or duplicated.
- Reset: RESETN=0 for 1 cycle with 2 beats in flight mid-packet → no OUT_VALID from them. The next beat is treated as the first beat (EXT_IDX=0).
- IDX_W=2, 6-beat packet with a strictly increasing I0 and MAXSEL=1 → EXT_IDX saturates at 3 and stays there.
